// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : IF stage of the 16-bit pipelined CPU. Owns the PC, issues word
//            fetches to the instruction cache over a req/ready handshake and
//            drives the IF/ID pipeline register. A one-entry skid buffer
//            absorbs a fetch that completes while decode is stalled. Redirects
//            flush the stage, and halt stops fetching until reset.
// Ports    : clk, reset_n          - clock, synchronous active-low reset
//            id_stall              - decode cannot accept IF/ID this cycle
//            redirect, redirect_pc - flush and restart fetch at redirect_pc
//            halt                  - stop fetching permanently
//            i_req, i_addr         - cache request and word address
//            i_ready, i_data       - cache completion and fetched word
//            if_inst, if_pc        - IF/ID instruction and its PC+1
//            if_valid              - IF/ID holds a real instruction
//            fetch_count           - instructions loaded into IF/ID (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        i_req,
  output logic [15:0] i_addr,
  input  logic        i_ready,
  input  logic [15:0] i_data,
  output logic [15:0] if_inst,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetchState_t;

  fetchState_t state;
  logic [15:0] pc;           // address of the current / next fetch
  logic [15:0] drainAddr;    // address of the request being drained
  logic [15:0] bufInst;      // skid buffer instruction (valid in FULL)
  logic [15:0] bufPc;        // skid buffer PC+1
  logic        haltPending;
  logic [15:0] pcPlusOne;

  assign pcPlusOne = pc + 16'd1;

  // The request line is gated by reset so an in-flight request is dropped
  // during the reset cycle itself, not one cycle later.
  assign i_req  = reset_n & ((state == FETCH) | (state == DRAIN));
  // While draining, the abandoned address must stay on the bus until the
  // cache answers it; the PC already holds the redirect target.
  assign i_addr = (state == DRAIN) ? drainAddr : pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      drainAddr   <= RESET_PC;
      bufInst     <= NOP_INST;
      bufPc       <= RESET_PC;
      haltPending <= 1'b0;
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_pc       <= RESET_PC;
      fetch_count <= 16'd0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            if (!i_ready) begin
              drainAddr <= pc;
              state     <= DRAIN;
            end
          end else if (halt) begin
            haltPending <= 1'b1;
            if (!id_stall) begin
              if_valid <= 1'b0;
              if_inst  <= NOP_INST;
            end
            if (!i_ready) begin
              drainAddr <= pc;
              state     <= DRAIN;
            end else begin
              state <= HALTED;   // the word returned this cycle is dropped
            end
          end else if (i_ready) begin
            pc <= pcPlusOne;
            if (!id_stall) begin
              if_valid    <= 1'b1;
              if_inst     <= i_data;
              if_pc       <= pcPlusOne;
              fetch_count <= fetch_count + 16'd1;
            end else begin
              bufInst <= i_data;
              bufPc   <= pcPlusOne;
              state   <= FULL;
            end
          end else if (!id_stall) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end
        end

        FULL: begin
          if (redirect) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            state    <= FETCH;
          end else if (halt) begin
            haltPending <= 1'b1;
            if (!id_stall) begin
              if_valid <= 1'b0;
              if_inst  <= NOP_INST;
            end
            state <= HALTED;
          end else if (!id_stall) begin
            if_valid    <= 1'b1;
            if_inst     <= bufInst;
            if_pc       <= bufPc;
            fetch_count <= fetch_count + 16'd1;
            state       <= FETCH;
          end
        end

        DRAIN: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (halt) begin
            haltPending <= 1'b1;
          end
          if (redirect || !id_stall) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end
          // The response is discarded; a halt seen in this same cycle counts.
          if (i_ready) begin
            state <= (haltPending || (halt && !redirect)) ? HALTED : FETCH;
          end
        end

        HALTED: begin
          if (!id_stall) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: a directed vector table
//            covering the hit stream, a miss, decode stall, redirect during a
//            miss, halt and reset mid-miss, followed by randomized traffic
//            against a behavioural model of the fetch stage and the cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ready;
  logic [15:0] i_data;
  logic [15:0] if_inst;
  logic [15:0] if_pc;
  logic        if_valid;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_stall   (id_stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ready    (i_ready),
    .i_data     (i_data),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .fetch_count(fetch_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rstn, stall, redir, hlt, rdy;
    logic [15:0] rpc;
    bit          eReq;
    logic [15:0] eAddr;
    bit          eValid;
    logic [15:0] eInst, ePc, eCnt;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input bit rstn, stall, redir, input logic [15:0] rpc,
                        input bit hlt, rdy, eReq, input logic [15:0] eAddr,
                        input bit eValid, input logic [15:0] eInst, ePc, eCnt);
    vec_t v;
    v.rstn = rstn; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.hlt = hlt; v.rdy = rdy; v.eReq = eReq; v.eAddr = eAddr;
    v.eValid = eValid; v.eInst = eInst; v.ePc = ePc; v.eCnt = eCnt;
    vecs.push_back(v);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
  } skid_t;

  logic [15:0] mPc, mDiscardAddr, mIfInst, mIfPc, mCount;
  bit          mHalted, mStopping, mDiscard, mIfValid;
  skid_t       mSkid[$];

  task automatic mBubble();
    mIfValid = 1'b0;
    mIfInst  = NOP;
  endtask

  task automatic mLoad(input logic [15:0] inst, input logic [15:0] pcv);
    mIfValid = 1'b1;
    mIfInst  = inst;
    mIfPc    = pcv;
    mCount   = mCount + 16'd1;
  endtask

  task automatic modelStep(input bit rstn, stall, redir, input logic [15:0] rpc,
                           input bit hlt, rdy, input logic [15:0] data);
    bit    req;
    skid_t e;
    if (!rstn) begin
      mPc = RST_PC; mHalted = 0; mStopping = 0; mDiscard = 0; mSkid.delete();
      mIfValid = 0; mIfInst = NOP; mIfPc = RST_PC; mCount = 16'd0;
      return;
    end
    if (mHalted) begin
      if (!stall) mBubble();
      return;
    end
    req = (mSkid.size() == 0);
    if (mDiscard) begin
      if (redir) begin
        mPc = rpc;
        mBubble();
      end else begin
        if (hlt) mStopping = 1;
        if (!stall) mBubble();
      end
      if (rdy) begin
        mDiscard = 0;
        mHalted  = mStopping;
      end
    end else if (redir || hlt) begin
      if (req && !rdy) begin
        mDiscard     = 1;
        mDiscardAddr = mPc;
      end else if (!redir) begin
        mHalted = 1;
      end
      if (redir) mPc = rpc;
      else       mStopping = 1;
      mSkid.delete();
      if (redir || !stall) mBubble();
    end else if (mSkid.size() != 0) begin
      if (!stall) begin
        e = mSkid.pop_front();
        mLoad(e.inst, e.pc);
      end
    end else if (rdy) begin
      mPc = mPc + 16'd1;
      if (!stall) mLoad(data, mPc);
      else        mSkid.push_back('{data, mPc});
    end else if (!stall) begin
      mBubble();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rstnV, stallV, redirV, haltV, rdyV, eReq, modelLive, cBusy;
    logic [15:0] rpcV, eAddr, dataV;
    int          cWait, haltedFor;

    // rstn stall redir rpc hlt rdy | req addr valid inst pc cnt
    addVec(0,0,0,16'h0,0,0, 0,16'h0000, 0,16'h0000,16'h0000,16'd0);
    addVec(1,0,0,16'h0,0,1, 1,16'h0000, 0,16'h0000,16'h0000,16'd0);
    addVec(1,0,0,16'h0,0,1, 1,16'h0001, 1,16'h1000,16'h0001,16'd1);
    addVec(1,0,0,16'h0,0,1, 1,16'h0002, 1,16'h1001,16'h0002,16'd2);
    addVec(1,0,0,16'h0,0,1, 1,16'h0003, 1,16'h1002,16'h0003,16'd3);
    addVec(1,0,0,16'h0,0,1, 1,16'h0004, 1,16'h1003,16'h0004,16'd4);
    // miss at 5: three wait cycles, then hit
    addVec(1,0,0,16'h0,0,0, 1,16'h0005, 1,16'h1004,16'h0005,16'd5);
    addVec(1,0,0,16'h0,0,0, 1,16'h0005, 0,16'h0000,16'h0005,16'd5);
    addVec(1,0,0,16'h0,0,0, 1,16'h0005, 0,16'h0000,16'h0005,16'd5);
    addVec(1,0,0,16'h0,0,1, 1,16'h0005, 0,16'h0000,16'h0005,16'd5);
    addVec(1,0,0,16'h0,0,1, 1,16'h0006, 1,16'h1005,16'h0006,16'd6);
    // decode stall for three cycles while address 7 completes
    addVec(1,1,0,16'h0,0,1, 1,16'h0007, 1,16'h1006,16'h0007,16'd7);
    addVec(1,1,0,16'h0,0,0, 0,16'h0000, 1,16'h1006,16'h0007,16'd7);
    addVec(1,1,0,16'h0,0,0, 0,16'h0000, 1,16'h1006,16'h0007,16'd7);
    addVec(1,0,0,16'h0,0,0, 0,16'h0000, 1,16'h1006,16'h0007,16'd7);
    addVec(1,0,0,16'h0,0,1, 1,16'h0008, 1,16'h1007,16'h0008,16'd8);
    // redirect to 0x40 while the miss at 9 is outstanding
    addVec(1,0,0,16'h0,0,0, 1,16'h0009, 1,16'h1008,16'h0009,16'd9);
    addVec(1,0,1,16'h0040,0,0, 1,16'h0009, 0,16'h0000,16'h0009,16'd9);
    addVec(1,0,0,16'h0,0,0, 1,16'h0009, 0,16'h0000,16'h0009,16'd9);
    addVec(1,0,0,16'h0,0,1, 1,16'h0009, 0,16'h0000,16'h0009,16'd9);
    addVec(1,0,0,16'h0,0,1, 1,16'h0040, 0,16'h0000,16'h0009,16'd9);
    // halt on a hit, then an ignored redirect to 0x80
    addVec(1,0,0,16'h0,1,1, 1,16'h0041, 1,16'h1040,16'h0041,16'd10);
    addVec(1,0,1,16'h0080,0,0, 0,16'h0000, 0,16'h0000,16'h0041,16'd10);
    addVec(1,0,0,16'h0,0,0, 0,16'h0000, 0,16'h0000,16'h0041,16'd10);
    addVec(1,0,0,16'h0,0,0, 0,16'h0000, 0,16'h0000,16'h0041,16'd10);
    addVec(0,0,0,16'h0,0,0, 0,16'h0000, 0,16'h0000,16'h0041,16'd10);
    // restart, run to a miss at 7, reset in the middle of it
    addVec(1,0,0,16'h0,0,1, 1,16'h0000, 0,16'h0000,16'h0000,16'd0);
    for (int k = 1; k <= 6; k++)
      addVec(1,0,0,16'h0,0,1, 1,16'(k), 1,16'(16'h1000 + k - 1),16'(k),16'(k));
    addVec(1,0,0,16'h0,0,0, 1,16'h0007, 1,16'h1006,16'h0007,16'd7);
    addVec(0,0,0,16'h0,0,0, 0,16'h0000, 0,16'h0000,16'h0007,16'd7);
    addVec(1,0,0,16'h0,0,0, 1,16'h0000, 0,16'h0000,16'h0000,16'd0);
    addVec(1,0,0,16'h0,0,1, 1,16'h0000, 0,16'h0000,16'h0000,16'd0);
    addVec(1,0,0,16'h0,0,0, 1,16'h0001, 1,16'h1000,16'h0001,16'd1);

    reset_n = 0; id_stall = 0; redirect = 0; redirect_pc = 16'h0;
    halt = 0; i_ready = 0; i_data = 16'h0;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      @(posedge clk); #1;
      reset_n     = vecs[k].rstn;
      id_stall    = vecs[k].stall;
      redirect    = vecs[k].redir;
      redirect_pc = vecs[k].rpc;
      halt        = vecs[k].hlt;
      i_ready     = vecs[k].rdy;
      i_data      = vecs[k].eAddr + 16'h1000;
      #5;
      chk1 ($sformatf("vec%0d i_req", k), i_req, vecs[k].eReq);
      if (vecs[k].eReq) chk16($sformatf("vec%0d i_addr", k), i_addr, vecs[k].eAddr);
      chk1 ($sformatf("vec%0d if_valid", k), if_valid, vecs[k].eValid);
      chk16($sformatf("vec%0d if_inst", k), if_inst, vecs[k].eInst);
      chk16($sformatf("vec%0d if_pc", k), if_pc, vecs[k].ePc);
      chk16($sformatf("vec%0d fetch_count", k), fetch_count, vecs[k].eCnt);
    end

    // ---------------- randomized traffic vs model ----------------
    modelLive = 0; cBusy = 0; cWait = 0; haltedFor = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rstnV  = (cyc != 0) && ($urandom_range(0, 299) != 0) && (haltedFor < 12);
      stallV = ($urandom_range(0, 9) < 3);
      redirV = ($urandom_range(0, 19) == 0);
      rpcV   = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom_range(0, 65535));
      haltV  = ($urandom_range(0, 59) == 0);
      eReq   = rstnV && modelLive && !mHalted && (mSkid.size() == 0);
      eAddr  = mDiscard ? mDiscardAddr : mPc;
      rdyV   = 0;
      if (eReq) begin
        if (!cBusy) begin
          cBusy = 1;
          cWait = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
        end
        rdyV = (cWait == 0);
      end
      dataV = eAddr ^ 16'h5A3C;

      reset_n = rstnV; id_stall = stallV; redirect = redirV;
      redirect_pc = rpcV; halt = haltV; i_ready = rdyV; i_data = dataV;
      #5;
      if (modelLive) begin
        chk1 ($sformatf("rnd%0d i_req", cyc), i_req, eReq);
        if (eReq) chk16($sformatf("rnd%0d i_addr", cyc), i_addr, eAddr);
        chk1 ($sformatf("rnd%0d if_valid", cyc), if_valid, mIfValid);
        chk16($sformatf("rnd%0d if_inst", cyc), if_inst, mIfInst);
        chk16($sformatf("rnd%0d if_pc", cyc), if_pc, mIfPc);
        chk16($sformatf("rnd%0d fetch_count", cyc), fetch_count, mCount);
      end

      if (modelLive || !rstnV) begin
        modelStep(rstnV, stallV, redirV, rpcV, haltV, rdyV, dataV);
        modelLive = 1;
      end
      if (!rstnV) cBusy = 0;
      else if (eReq) begin
        if (rdyV) cBusy = 0;
        else      cWait--;
      end
      haltedFor = mHalted ? haltedFor + 1 : 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
